// File: rtl/apb_manager_if.sv
// Bundle of requester-side and APB-side signals around apb_manager.
// The manager uses the master modport; the requester/subordinate side
// (bench or surrounding logic) uses the slave modport.
interface apb_manager_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  // Requester side
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [AddrWidth-1:0]   req_addr;
  logic [DataWidth-1:0]   req_wdata;
  logic [DataWidth/8-1:0] req_strb;
  logic [2:0]             req_prot;
  logic                   rsp_valid;
  logic [DataWidth-1:0]   rsp_rdata;
  logic                   rsp_error;
  // APB side
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [AddrWidth-1:0]   paddr;
  logic [DataWidth-1:0]   pwdata;
  logic [DataWidth/8-1:0] pstrb;
  logic [2:0]             pprot;
  logic [DataWidth-1:0]   prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_manager.sv
// APB manager: turns a valid/ready request into an APB SETUP/ACCESS
// transfer and returns a one-cycle response pulse. Back-to-back requests
// go straight from ACCESS to SETUP without an idle cycle.
// Optional feature: define APB_MANAGER_TIMEOUT_EN to abort an ACCESS that
// waits TimeoutCycles cycles for pready, answering with rsp_error=1.
module apb_manager #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input logic          clk,
  input logic          reset,
  apb_manager_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("apb_manager: TimeoutCycles must be at least 1");
  end
  if ((DataWidth % 8) != 0) begin : g_bad_width
    $error("apb_manager: DataWidth must be a multiple of 8");
  end

  state_e                 state_q, state_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [AddrWidth-1:0]   paddr_q, paddr_d;
  logic [DataWidth-1:0]   pwdata_q, pwdata_d;
  logic [DataWidth/8-1:0] pstrb_q, pstrb_d;
  logic [2:0]             pprot_q, pprot_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DataWidth-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_error_q, rsp_error_d;
  logic                   accept;

`ifdef APB_MANAGER_TIMEOUT_EN
  localparam int WaitW = $clog2(TimeoutCycles + 1);
  logic [WaitW-1:0] wait_q, wait_d;
`endif

  // A new request can be taken when idle or when the current transfer ends now.
  assign bus.req_ready = (state_q == IDLE) || ((state_q == ACCESS) && bus.pready);

  // Next-state, capture and response logic.
  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    accept      = 1'b0;
`ifdef APB_MANAGER_TIMEOUT_EN
    wait_d      = wait_q;
`endif

    case (state_q)
      IDLE: accept = bus.req_valid;
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_MANAGER_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      ACCESS: begin
        if (bus.pready) begin
          // prdata/pslverr are only looked at in this completion cycle.
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
          rsp_error_d = bus.pslverr;
          if (bus.req_valid) begin
            accept = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
`ifdef APB_MANAGER_TIMEOUT_EN
          if (wait_q == WaitW'(TimeoutCycles - 1)) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_error_d = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d  = SETUP;
      pwrite_d = bus.req_write;
      paddr_d  = bus.req_addr;
      pwdata_d = bus.req_wdata;
      pstrb_d  = bus.req_strb;
      pprot_d  = bus.req_prot;
    end

    // psel/penable are registered copies of where the FSM is heading.
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
`ifdef APB_MANAGER_TIMEOUT_EN
      wait_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
`ifdef APB_MANAGER_TIMEOUT_EN
      wait_q      <= wait_d;
`endif
    end
  end

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.pprot     = pprot_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

endmodule
